// File: rtl/ezrisc_pkg.sv
// ezrisc_pkg: state encoding, opcode constants, alu_op constants and
// instruction classes shared by the control unit and its decoder.
package ezrisc_pkg;

  typedef enum logic [3:0] {
    ST_RESET = 4'd0,
    ST_T0    = 4'd1,
    ST_T1    = 4'd2,
    ST_T2    = 4'd3,
    ST_T3    = 4'd4,
    ST_T4    = 4'd5,
    ST_T5    = 4'd6,
    ST_T6    = 4'd7,
    ST_HALT  = 4'd8
  } state_t;

  typedef enum logic [2:0] {
    CLS_RTYPE   = 3'd0,
    CLS_IMM     = 3'd1,
    CLS_UNARY   = 3'd2,
    CLS_MULDIV  = 3'd3,
    CLS_NOP     = 3'd4,
    CLS_HALT    = 3'd5,
    CLS_ILLEGAL = 3'd6
  } instr_class_t;

  localparam logic [4:0] OP_ADD  = 5'd3;
  localparam logic [4:0] OP_SUB  = 5'd4;
  localparam logic [4:0] OP_SHR  = 5'd5;
  localparam logic [4:0] OP_SHL  = 5'd6;
  localparam logic [4:0] OP_ROR  = 5'd7;
  localparam logic [4:0] OP_ROL  = 5'd8;
  localparam logic [4:0] OP_AND  = 5'd9;
  localparam logic [4:0] OP_OR   = 5'd10;
  localparam logic [4:0] OP_ADDI = 5'd11;
  localparam logic [4:0] OP_ANDI = 5'd12;
  localparam logic [4:0] OP_ORI  = 5'd13;
  localparam logic [4:0] OP_MUL  = 5'd14;
  localparam logic [4:0] OP_DIV  = 5'd15;
  localparam logic [4:0] OP_NEG  = 5'd16;
  localparam logic [4:0] OP_NOT  = 5'd17;
  localparam logic [4:0] OP_NOP  = 5'd26;
  localparam logic [4:0] OP_HALT = 5'd27;

  localparam logic [3:0] ALU_AND = 4'h0;
  localparam logic [3:0] ALU_OR  = 4'h1;
  localparam logic [3:0] ALU_ADD = 4'h2;
  localparam logic [3:0] ALU_SUB = 4'h3;
  localparam logic [3:0] ALU_SHR = 4'h4;
  localparam logic [3:0] ALU_SHL = 4'h5;
  localparam logic [3:0] ALU_ROR = 4'h6;
  localparam logic [3:0] ALU_ROL = 4'h7;
  localparam logic [3:0] ALU_MUL = 4'h8;
  localparam logic [3:0] ALU_DIV = 4'h9;
  localparam logic [3:0] ALU_NEG = 4'hA;
  localparam logic [3:0] ALU_NOT = 4'hB;

endpackage

// File: rtl/control_unit_instr_decoder.sv
// instr_decoder: combinational opcode -> (instruction class, alu_op).
// CONTROL_UNIT_MULDIV_EN: when defined, mul/div decode as CLS_MULDIV;
// otherwise they fall through to CLS_ILLEGAL.
module instr_decoder
  import ezrisc_pkg::*;
(
  input  logic [4:0]   opcode,
  output instr_class_t instr_class,
  output logic [3:0]   alu_op
);

  // Opcode lookup; non-ALU classes carry alu_op 0.
  always_comb begin
    instr_class = CLS_ILLEGAL;
    alu_op      = ALU_AND;
    case (opcode)
      OP_ADD:  begin instr_class = CLS_RTYPE; alu_op = ALU_ADD; end
      OP_SUB:  begin instr_class = CLS_RTYPE; alu_op = ALU_SUB; end
      OP_SHR:  begin instr_class = CLS_RTYPE; alu_op = ALU_SHR; end
      OP_SHL:  begin instr_class = CLS_RTYPE; alu_op = ALU_SHL; end
      OP_ROR:  begin instr_class = CLS_RTYPE; alu_op = ALU_ROR; end
      OP_ROL:  begin instr_class = CLS_RTYPE; alu_op = ALU_ROL; end
      OP_AND:  begin instr_class = CLS_RTYPE; alu_op = ALU_AND; end
      OP_OR:   begin instr_class = CLS_RTYPE; alu_op = ALU_OR;  end
      OP_ADDI: begin instr_class = CLS_IMM;   alu_op = ALU_ADD; end
      OP_ANDI: begin instr_class = CLS_IMM;   alu_op = ALU_AND; end
      OP_ORI:  begin instr_class = CLS_IMM;   alu_op = ALU_OR;  end
`ifdef CONTROL_UNIT_MULDIV_EN
      OP_MUL:  begin instr_class = CLS_MULDIV; alu_op = ALU_MUL; end
      OP_DIV:  begin instr_class = CLS_MULDIV; alu_op = ALU_DIV; end
`endif
      OP_NEG:  begin instr_class = CLS_UNARY; alu_op = ALU_NEG; end
      OP_NOT:  begin instr_class = CLS_UNARY; alu_op = ALU_NOT; end
      OP_NOP:  begin instr_class = CLS_NOP;   alu_op = ALU_AND; end
      OP_HALT: begin instr_class = CLS_HALT;  alu_op = ALU_AND; end
      default: begin instr_class = CLS_ILLEGAL; alu_op = ALU_AND; end
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// control_unit: fetch/decode/execute sequencer for the ezrisc datapath.
// Strobes are a combinational decode of the current state and opcode.
// CONTROL_UNIT_MULDIV_EN (in the decoder) enables mul/div and state T6.
module control_unit
  import ezrisc_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] ir,
  output logic        pc_out, pc_in, inc_pc, mar_in, mdr_in, mdr_out,
  output logic        read, write, ir_in, y_in, z_in, z_low_out,
  output logic        z_high_out, c_out,
  output logic        gra, grb, grc, r_in, r_out, ba_out,
  output logic        hi_in, lo_in, hi_out, lo_out, outport_in, inport_out,
  output logic [3:0]  alu_op,
  output logic        run,
  output logic        illegal_op
);

  state_t       state_q, state_d;
  logic         illegal_q, illegal_d;
  instr_class_t cls;
  logic [3:0]   dec_alu;
  logic         unused_ir;

  // Only the opcode field steers sequencing; register/immediate fields
  // go straight to the datapath.
  assign unused_ir = ^ir[26:0];

  instr_decoder u_instr_decoder (
    .opcode      (ir[31:27]),
    .instr_class (cls),
    .alu_op      (dec_alu)
  );

  // Next-state and sticky illegal-opcode flag.
  always_comb begin
    state_d   = state_q;
    illegal_d = illegal_q;
    case (state_q)
      ST_RESET: state_d = ST_T0;
      ST_T0:    state_d = ST_T1;
      ST_T1:    state_d = ST_T2;
      ST_T2:    state_d = ST_T3;
      ST_T3: begin
        case (cls)
          CLS_NOP:     state_d = ST_T0;
          CLS_HALT:    state_d = ST_HALT;
          CLS_ILLEGAL: begin state_d = ST_T0; illegal_d = 1'b1; end
          default:     state_d = ST_T4;
        endcase
      end
      ST_T4:    state_d = ST_T5;
      ST_T5: begin
        if (cls == CLS_MULDIV) state_d = ST_T6;
        else                   state_d = ST_T0;
      end
      ST_T6:    state_d = ST_T0;
      ST_HALT:  state_d = ST_HALT;
      default:  state_d = ST_RESET;
    endcase
  end

  // State and flag registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= ST_RESET;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
    end
  end

  assign illegal_op = illegal_q;

  // Strobe decode: everything defaults to 0, each state raises its own set.
  always_comb begin
    pc_out = 1'b0; pc_in = 1'b0; inc_pc = 1'b0; mar_in = 1'b0;
    mdr_in = 1'b0; mdr_out = 1'b0; read = 1'b0; write = 1'b0;
    ir_in = 1'b0; y_in = 1'b0; z_in = 1'b0; z_low_out = 1'b0;
    z_high_out = 1'b0; c_out = 1'b0;
    gra = 1'b0; grb = 1'b0; grc = 1'b0; r_in = 1'b0; r_out = 1'b0;
    ba_out = 1'b0; hi_in = 1'b0; lo_in = 1'b0; hi_out = 1'b0;
    lo_out = 1'b0; outport_in = 1'b0; inport_out = 1'b0;
    alu_op = ALU_AND;
    run    = 1'b1;
    case (state_q)
      ST_T0: begin pc_out = 1'b1; mar_in = 1'b1; inc_pc = 1'b1; z_in = 1'b1; alu_op = ALU_ADD; end
      ST_T1: begin z_low_out = 1'b1; pc_in = 1'b1; read = 1'b1; mdr_in = 1'b1; end
      ST_T2: begin mdr_out = 1'b1; ir_in = 1'b1; end
      ST_T3: begin
        case (cls)
          CLS_RTYPE, CLS_IMM, CLS_UNARY: begin grb = 1'b1; r_out = 1'b1; y_in = 1'b1; end
          CLS_MULDIV: begin gra = 1'b1; r_out = 1'b1; y_in = 1'b1; end
          default: begin end
        endcase
      end
      ST_T4: begin
        alu_op = dec_alu;
        z_in   = 1'b1;
        case (cls)
          CLS_RTYPE:             begin grc = 1'b1; r_out = 1'b1; end
          CLS_IMM:               begin c_out = 1'b1; end
          CLS_UNARY, CLS_MULDIV: begin grb = 1'b1; r_out = 1'b1; end
          default: begin end
        endcase
      end
      ST_T5: begin
        z_low_out = 1'b1;
        if (cls == CLS_MULDIV) begin
          lo_in = 1'b1;
        end else begin
          gra  = 1'b1;
          r_in = 1'b1;
        end
      end
      ST_T6:    begin z_high_out = 1'b1; hi_in = 1'b1; end
      ST_RESET: run = 1'b0;
      ST_HALT:  run = 1'b0;
      default:  run = 1'b0;
    endcase
  end

endmodule
